qsysdemo_led_pio: RTL
=====================

# qsysdemo_led_pio

Avalon-MM slave output port with blink. It drives board LEDs from the Nios II system and is the write-side counterpart of the key input port on the same interconnect. Software writes an output data register, either whole or through bit-set/bit-clear strobes. A free-running blink timer can gate selected bits on and off without CPU involvement.

## Interface
- WIDTH, 8, number of output bits, legal range 1..32.
- RESET_VALUE, 0, value of the DATA register after reset, WIDTH bits.
- clk  input  1  system clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  3  Avalon word address.
- chipselect  input  1  slave select; writes are ignored when low.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data; bits above WIDTH are ignored except at PERIOD.
- readdata  output  32  registered read data.
- out_port  output  WIDTH  LED drive.

## Operation
- Register map (word address):
  - 0 DATA: R/W, WIDTH bits.
  - 1 BLINK_EN: R/W, WIDTH bits; a 1 in a bit position enables blinking for that bit.
  - 2 PERIOD: R/W, 24 bits; blink half-period in clk cycles; 0 disables the timer.
  - 3 STATUS: read-only; bit0 = phase, other bits 0.
  - 4 OUTSET: write-only; DATA <= DATA | writedata[WIDTH-1:0]; reads return 0.
  - 5 OUTCLEAR: write-only; DATA <= DATA & ~writedata[WIDTH-1:0]; reads return 0.
  - 6, 7: reserved; writes are ignored and reads return 0.
- A write occurs on a clk edge where chipselect=1 and write_n=0. The addressed register updates on that edge.
- Blink timer: a 24-bit counter cnt and a phase bit.
  - PERIOD==0: cnt held at 0, phase held at 1.
  - PERIOD!=0: cnt increments each cycle. When cnt==PERIOD-1, cnt <= 0 and phase toggles.
  - A write to PERIOD forces cnt <= 0 and phase <= 1 on that edge; the new value takes effect from the next cycle.
- out_port[i] = BLINK_EN[i] ? (DATA[i] & phase) : DATA[i]. This is combinational from registers only, so out_port is glitch-free at register granularity.
- A read of DATA returns the DATA register, not out_port. Unused upper readdata bits are 0.
- readdata <= mux(address) on every clk edge, independent of chipselect and write_n.

## Timing
- Reset values:
  - DATA = RESET_VALUE
  - BLINK_EN = 0, PERIOD = 0
  - cnt = 0, phase = 1
  - readdata = 0
  - out_port = RESET_VALUE
- Write-to-output latency: a write on edge N is visible on out_port after edge N.
- Read latency: 1 cycle. With address held from edge N-1, readdata is valid after edge N. A write and a read of the same register in the same cycle return the old value.
- Blink waveform: phase stays 1 for PERIOD cycles, then 0 for PERIOD cycles, measured from the PERIOD write or from reset/wrap.
- Simultaneous events:
  - A timer wrap and a DATA, OUTSET or OUTCLEAR write on the same edge both take effect.
  - A PERIOD write on the same edge as a wrap: the write wins (cnt=0, phase=1).
- Reduction of PERIOD below the current cnt occurs only through a PERIOD write, which resets cnt, so the counter never overruns.
- Reset mid-operation: all state returns to its reset value asynchronously; out_port = RESET_VALUE immediately.
- No waitrequest: the slave accepts every access with zero wait states.

## Test plan
- Reset check: with RESET_VALUE=8'hA5, assert reset_n=0 mid-run -> out_port=8'hA5 and readdata=0 asynchronously. Read DATA -> 32'h000000A5.
- Set/clear: write DATA=8'h0F, then OUTSET=8'h30, then OUTCLEAR=8'h05 -> out_port reads 8'h0F, 8'h3F, 8'h3A after each respective edge. Reads of addresses 4 and 5 return 0.
- Blink: DATA=8'hFF, BLINK_EN=8'h01, PERIOD=3 -> out_port[0] is high 3 cycles, low 3 cycles, repeating. out_port[7:1] stays 7'h7F. STATUS bit0 tracks phase with 1-cycle read latency.
- Period rewrite: write PERIOD=5 while phase=0 -> phase=1 and cnt=0 after that edge; the next toggle occurs 5 cycles later. PERIOD=0 -> phase stays 1 permanently.
- Gating and reserved addresses: write_n=0 with chipselect=0 to DATA -> no change. Writes to addresses 6 and 7 -> no register changes and reads return 0.
- Collision: OUTCLEAR=8'h01 on the same edge as a phase wrap -> DATA[0] cleared and phase toggled, both visible on the following cycle.

Source files
------------

// File: rtl/qsysdemo_led_pio.sv
// Avalon-MM LED output port: DATA register with set/clear strobes and a
// free-running blink timer that gates selected bits by a shared phase.
module qsysdemo_led_pio #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    logic             wr_en;
    logic             period_wr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] blink_en;
    logic [23:0]      period;
    logic [23:0]      cnt;
    logic             phase;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign period_wr    = wr_en && (address == ADDR_PERIOD);
    assign wdata        = writedata[WIDTH-1:0];
    // writedata bits above WIDTH only matter for PERIOD
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
            blink_en <= '0;
            period   <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:     data_reg <= wdata;
                ADDR_BLINK_EN: blink_en <= wdata;
                ADDR_PERIOD:   period   <= writedata[23:0];
                ADDR_OUTSET:   data_reg <= data_reg | wdata;
                ADDR_OUTCLEAR: data_reg <= data_reg & ~wdata;
                default:       ;
            endcase
        end
    end

    // A PERIOD write restarts the waveform and outranks a same-edge wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (period_wr || (period == 24'd0)) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == period - 24'd1) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 24'd1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:     rd_mux[WIDTH-1:0] = data_reg;
            ADDR_BLINK_EN: rd_mux[WIDTH-1:0] = blink_en;
            ADDR_PERIOD:   rd_mux[23:0]      = period;
            ADDR_STATUS:   rd_mux[0]         = phase;
            default:       rd_mux            = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign out_port = data_reg & ~(blink_en & {WIDTH{~phase}});

endmodule
